// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmitter, start + 8 data LSB-first + optional parity + stop, prescale CLK cycles per bit.
module uart_tx_frame #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     P_DATA,
    input  logic                      DATA_VALID,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      TX_OUT,
    output logic                      busy
);
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t                    r_state, w_state_nxt;
    logic [PRESCALE_WIDTH-1:0] r_cnt, w_cnt_nxt, r_pre, w_pre_nxt, w_top;
    logic [IW-1:0]             r_idx, w_idx_nxt;
    logic [DATA_WIDTH-1:0]     r_data, w_data_nxt;
    logic                      r_par_en, w_par_en_nxt, r_par_typ, w_par_typ_nxt;
    logic                      r_tx, w_tx_nxt, r_busy, w_busy_nxt, w_last;
    // prescale=0 behaves as 1: every cycle is a bit boundary
    assign w_top  = (r_pre == '0) ? '0 : r_pre - PRESCALE_WIDTH'(1);
    assign w_last = r_cnt >= w_top;
    assign TX_OUT = r_tx;
    assign busy   = r_busy;
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_pre     <= '0;
            r_data    <= '0;
            r_par_en  <= 1'b0;
            r_par_typ <= 1'b0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_idx     <= w_idx_nxt;
            r_pre     <= w_pre_nxt;
            r_data    <= w_data_nxt;
            r_par_en  <= w_par_en_nxt;
            r_par_typ <= w_par_typ_nxt;
            r_tx      <= w_tx_nxt;
            r_busy    <= w_busy_nxt;
        end
    end
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = w_last ? '0 : r_cnt + PRESCALE_WIDTH'(1);
        w_idx_nxt     = r_idx;
        w_pre_nxt     = r_pre;
        w_data_nxt    = r_data;
        w_par_en_nxt  = r_par_en;
        w_par_typ_nxt = r_par_typ;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                w_idx_nxt = '0;
                if (DATA_VALID) begin
                    w_state_nxt   = START;
                    w_data_nxt    = P_DATA;
                    w_par_en_nxt  = PAR_EN;
                    w_par_typ_nxt = PAR_TYP;
                    w_pre_nxt     = prescale;
                end
            end
            START:  if (w_last) w_state_nxt = DATA;
            DATA: begin
                if (w_last) begin
                    if (r_idx == IW'(DATA_WIDTH - 1))
                        w_state_nxt = r_par_en ? PARITY : STOP;
                    else
                        w_idx_nxt = r_idx + IW'(1);
                end
            end
            PARITY: if (w_last) w_state_nxt = STOP;
            STOP:   if (w_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        // outputs are derived from the next state so they register in step with it
        w_busy_nxt = w_state_nxt != IDLE;
        w_tx_nxt   = (w_state_nxt == START)  ? 1'b0 :
                     (w_state_nxt == DATA)   ? r_data[w_idx_nxt] :
                     (w_state_nxt == PARITY) ? (^r_data) ^ r_par_typ : 1'b1;
    end
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: directed frames checked cycle by cycle against a scoreboard of expected frames.
module tb_uart_tx_frame;
    logic       CLK, RST, DATA_VALID, PAR_EN, PAR_TYP, TX_OUT, busy;
    logic [7:0] P_DATA;
    logic [5:0] prescale;
    int         n_cmp = 0;
    int         n_err = 0;
    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       pt;
        int         pre;
    } frm_t;
    frm_t q[$];

    uart_tx_frame dut (
        .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .prescale(prescale),
        .TX_OUT(TX_OUT), .busy(busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_tx"}, TX_OUT, 1);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic send(input logic [7:0] d, input logic pe, input logic pt, input int pre, input bit hold);
        P_DATA = d; PAR_EN = pe; PAR_TYP = pt; prescale = 6'(pre); DATA_VALID = 1'b1;
        q.push_back('{d, pe, pt, pre});
        @(negedge CLK);
        if (!hold) DATA_VALID = 1'b0;
    endtask

    // entered on the first start-bit cycle; returns on the idle cycle after the frame
    task automatic check_frame(input int abort_at, input bit disturb);
        frm_t        f;
        logic [10:0] bits;
        logic        par;
        int          n, bc;
        if (q.size() == 0) begin
            chk("queue_empty", 1, 0);
            return;
        end
        f    = q.pop_front();
        n    = f.pe ? 11 : 10;
        par  = f.pt ? ~^f.d : ^f.d;
        bits = f.pe ? {1'b1, par, f.d, 1'b0} : {2'b11, f.d, 1'b0};
        bc   = 0;
        for (int i = 0; i < n * f.pre; i++) begin
            chk($sformatf("tx_c%0d", i), TX_OUT, bits[i / f.pre]);
            chk($sformatf("busy_c%0d", i), busy, 1);
            bc += (busy === 1'b1) ? 1 : 0;
            if (i == abort_at) begin
                #2 RST = 1'b0;
                #1 chk("async_rst_tx", TX_OUT, 1);
                chk("async_rst_busy", busy, 0);
                return;
            end
            if (disturb && i == 20) begin
                DATA_VALID = 1'b1; P_DATA = 8'h55; prescale = 6'd16;
            end
            if (disturb && i == 21) begin
                DATA_VALID = 1'b0; P_DATA = 8'h00; PAR_EN = ~PAR_EN; PAR_TYP = ~PAR_TYP;
            end
            @(negedge CLK);
        end
        chk("busy_len", bc, n * f.pre);
        chk_idle("post_frame");
    endtask

    initial begin
        RST = 1'b1; DATA_VALID = 1'b0; P_DATA = 8'h00; PAR_EN = 1'b0; PAR_TYP = 1'b0; prescale = 6'd8;
        #1 RST = 1'b0;
        @(negedge CLK);
        chk_idle("reset");
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        chk_idle("after_release");
        send(8'hAB, 1'b0, 1'b0, 8, 1'b0);
        check_frame(-1, 1'b0);
        send(8'hCD, 1'b1, 1'b0, 16, 1'b0);
        check_frame(-1, 1'b0);
        send(8'hCD, 1'b1, 1'b1, 16, 1'b0);
        check_frame(-1, 1'b0);
        send(8'hEF, 1'b1, 1'b1, 32, 1'b0);
        check_frame(-1, 1'b0);
        send(8'h96, 1'b0, 1'b0, 8, 1'b0);
        check_frame(-1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk_idle($sformatf("no_queue_%0d", i));
        end
        send(8'h3C, 1'b1, 1'b0, 8, 1'b1);
        check_frame(-1, 1'b0);
        q.push_back('{8'h3C, 1'b1, 1'b0, 8});
        @(negedge CLK);
        DATA_VALID = 1'b0;
        check_frame(-1, 1'b0);
        send(8'hA5, 1'b0, 1'b0, 8, 1'b0);
        check_frame(4 * 8 + 3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk_idle($sformatf("in_reset_%0d", i));
        end
        RST = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk_idle($sformatf("post_reset_%0d", i));
        end
        send(8'h5A, 1'b1, 1'b0, 8, 1'b0);
        check_frame(-1, 1'b0);
        send(8'h81, 1'b0, 1'b0, 16, 1'b0);
        check_frame(-1, 1'b0);
        chk("queue_left", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
Serial UART transmitter that converts a parallel byte into a UART frame on a single line. The frame is a start bit, 8 data bits sent LSB first, an optional parity bit and a stop bit. It is the stage directly upstream of the UART receiver: TX_OUT drives the receiver's RX_IN. Each bit is held for prescale system-clock cycles, and prescale uses the same encoding as the receiver (8/16/32), so both sides share one clock and one bit-timing convention.

Parameters:
DATA_WIDTH, 8, data bits per frame
PRESCALE_WIDTH, 6, width of the prescale input and the bit-period counter

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  asynchronous active-low reset
P_DATA  input  8  byte to transmit
DATA_VALID  input  1  request pulse/level; accepted only when busy=0
PAR_EN  input  1  1 = insert parity bit
PAR_TYP  input  1  0 = even parity, 1 = odd parity
prescale  input  6  CLK cycles per bit; supported values are 8, 16 and 32
TX_OUT  output  1  serial line, idles high
busy  output  1  high from the start bit through the last stop-bit cycle

Behaviour:
- Reset: the asynchronous assert (RST=0) immediately forces the following, including mid-frame:
  - TX_OUT=1, busy=0
  - state=IDLE
  - bit counter, bit index and shadow registers cleared
  - The partial frame is abandoned. There is no resume after reset release.
- All outputs are registered. No combinational path runs from any input to TX_OUT or busy.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - TX_OUT=1, busy=0.
  - If DATA_VALID=1, latch P_DATA, PAR_EN, PAR_TYP and prescale into shadow registers and go to START.
- START: TX_OUT=0 for prescale cycles, busy=1.
- DATA:
  - Bits P_DATA[0]..P_DATA[7] in order, each held prescale cycles.
  - After bit 7, go to PARITY if the latched PAR_EN=1, else go to STOP.
- PARITY:
  - TX_OUT = ^data when PAR_TYP=0 (even), ~^data when PAR_TYP=1 (odd).
  - Held prescale cycles.
- STOP: TX_OUT=1 for prescale cycles, then IDLE.
- Latency: the first start-bit cycle appears on TX_OUT on the cycle after acceptance. busy rises in that same cycle.
- Frame duration: busy is high for exactly 10×prescale cycles without parity, 11×prescale cycles with parity.
- Bit timing:
  - The counter runs 0..prescale-1 and wraps to 0 on each bit boundary, advancing the bit index/state.
  - prescale=0 is treated as 1; it is not a supported setting.
- Back-to-back frames:
  - After the last STOP cycle the block spends at least one cycle in IDLE (TX_OUT=1, busy=0) before any new start bit.
  - A request held high continuously therefore yields frames separated by exactly one idle cycle.
- DATA_VALID while busy=1 is ignored. It is not queued.
- Changes to P_DATA, PAR_EN, PAR_TYP or prescale during a frame have no effect on that frame; the shadow registers are used.
- DATA_VALID asserted in the same cycle as reset release is not accepted; acceptance starts on the first rising edge with RST=1.

Test Plan:
1. prescale=8, PAR_EN=0, P_DATA=0xAB with a one-cycle DATA_VALID -> TX_OUT sequence is 0,1,1,0,1,0,1,0,1,1, each held 8 cycles. busy is high for 80 cycles. The UART receiver in loopback yields P_DATA=0xAB with data_valid.
2. prescale=16, PAR_EN=1, PAR_TYP=0, 0xCD (five ones) -> parity bit=1 at bit slot 9. busy is high for 176 cycles. Then with PAR_TYP=1 -> parity bit=0.
3. prescale=32, PAR_EN=1, PAR_TYP=1, 0xEF (seven ones) -> parity bit=0. busy is high for 352 cycles. The receiver yields 0xEF.
4. Second DATA_VALID with P_DATA=0x55 pulsed mid-frame, and P_DATA changed to 0x00 while busy -> current frame is unaltered and 0x55 is never transmitted. DATA_VALID held high across two frames -> exactly one idle-high cycle between the stop bit and the next start bit.
5. RST=0 asserted during data bit 3 of a prescale=8 frame -> TX_OUT=1 and busy=0 asynchronously, before the next CLK edge. After release, TX_OUT stays 1 until a new DATA_VALID, and the next frame is complete and correct.
6. prescale switched from 8 to 16 between frames -> the first frame uses 8-cycle bits and the second uses 16-cycle bits. A prescale change during a frame has no effect.
